wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//   Shares the register file's single write port (WriteEnable/WriteRegister/
//   WriteData) among NUM_REQ write-back requesters (ALU, load unit, mul/div)
//   plus a priority debug/loader port. Round-robin grant, valid/ready handshake,
//   registered outputs driving the register file directly. Writes to $0 are
//   accepted but never reach the register file.
// PARAMETERS
//   NUM_REQ   3   number of write-back requesters (2..8)
//   CNT_W     16  width of the saturating contention counter
// PORTS
//   clk            in   1              clock; all state changes on posedge
//   reset          in   1              synchronous, active-high
//   req_valid      in   NUM_REQ        requester i has a write pending
//   req_reg        in   5*NUM_REQ      dest reg of requester i, bits [5i+4:5i]
//   req_data       in   32*NUM_REQ     write data of requester i, bits [32i+31:32i]
//   req_ready      out  NUM_REQ        one-hot (or zero) grant; combinational
//   dbg_we         in   1              debug/loader write request, top priority
//   dbg_reg        in   5              debug destination register
//   dbg_data       in   32             debug write data
//   WriteEnable    out  1              to register file, registered
//   WriteRegister  out  5              to register file, registered
//   WriteData      out  32             to register file, registered
//   grant_id       out  3              index of last accepted requester, registered
//   contention_cnt out  CNT_W          cycles with >=1 valid requester not granted
// BEHAVIOUR
//   - Clock is clk; reset is synchronous and active-high.
//   - Reset (any cycle, incl. mid-transfer): WriteEnable=0, WriteRegister=0,
//     WriteData=0, grant_id=0, contention_cnt=0, rr pointer=0; req_ready=0
//     while reset high. A write accepted in the reset cycle is discarded.
//   - Transfer for requester i: req_valid[i] & req_ready[i] at a posedge.
//     Requester must hold valid/reg/data stable until transfer.
//   - Grant (combinational): if dbg_we, req_ready=0. Else first valid
//     requester scanning ptr, ptr+1, ... mod NUM_REQ gets req_ready=1; others 0.
//     req_ready never asserted without matching req_valid.
//   - Pointer: after transfer by i, ptr <= (i+1) mod NUM_REQ; unchanged on
//     idle cycles and on dbg cycles.
//   - Latency: 1 cycle. Source (dbg or granted req) in cycle N ->
//     WriteEnable=1, WriteRegister/WriteData = source values in cycle N+1.
//   - Register 0: if selected dest == 0, transfer completes normally but
//     WriteEnable=0 next cycle (WriteRegister/WriteData still updated).
//   - No source in cycle N -> WriteEnable=0 in N+1; WriteRegister/WriteData hold.
//   - grant_id updates only on requester transfers (not dbg).
//   - contention_cnt: +1 each cycle where (req_valid & ~req_ready) != 0
//     (includes dbg-blocked cycles); saturates at all-ones, never wraps.
//   - Throughput: one write per cycle; a continuously valid requester waits
//     at most NUM_REQ-1 cycles absent dbg_we.
// TESTING
//   1 reset: assert reset 2 cycles with all valid -> req_ready=0, WriteEnable=0,
//     contention_cnt=0, all outputs 0.
//   2 single: req_valid=001, reg=5, data=0xDEADBEEF -> ready=001 same cycle;
//     next cycle WriteEnable=1, WriteRegister=5, WriteData=0xDEADBEEF, grant_id=0.
//   3 round robin: req_valid=111 held, 6 cycles -> grants 0,1,2,0,1,2;
//     contention_cnt=6 after 6 cycles.
//   4 $0: requester 1 writes reg 0 data 0x1234 -> ready=010, next cycle
//     WriteEnable=0, grant_id=1, ptr advances to 2.
//   5 dbg priority: dbg_we=1 reg=31 data=0xA5A5A5A5 with req_valid=111 ->
//     req_ready=000, next cycle WriteEnable=1 reg 31; ptr unchanged; cnt +1.
//   6 saturation/reset: CNT_W=4, all valid 20 cycles -> cnt=15 held; reset
//     one cycle after a transfer -> WriteEnable=0 following cycle, cnt=0.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the register file's single write port among
// NUM_REQ round-robin requesters plus a top-priority debug/loader port.
// Outputs toward the register file are registered (1-cycle latency); writes
// to $0 complete the handshake but never assert WriteEnable.
module wb_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [5*NUM_REQ-1:0]   req_reg,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic                   dbg_we,
    input  logic [4:0]             dbg_reg,
    input  logic [31:0]            dbg_data,
    output logic                   WriteEnable,
    output logic [4:0]             WriteRegister,
    output logic [31:0]            WriteData,
    output logic [2:0]             grant_id,
    output logic [CNT_W-1:0]       contention_cnt
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_REQ - 1);
    localparam logic [3:0] N4       = 4'(NUM_REQ);

    // Requester fields padded out to 8 slots so a 3-bit index is always in range.
    logic        w_valid_arr [8];
    logic [4:0]  w_reg_arr   [8];
    logic [31:0] w_data_arr  [8];

    for (genvar g = 0; g < 8; g++) begin : g_unpack
        if (g < NUM_REQ) begin : g_used
            assign w_valid_arr[g] = req_valid[g];
            assign w_reg_arr[g]   = req_reg[5*g +: 5];
            assign w_data_arr[g]  = req_data[32*g +: 32];
        end else begin : g_unused
            assign w_valid_arr[g] = 1'b0;
            assign w_reg_arr[g]   = '0;
            assign w_data_arr[g]  = '0;
        end
    end

    logic [2:0]       r_ptr;
    logic             r_we;
    logic [4:0]       r_wreg;
    logic [31:0]      r_wdata;
    logic [2:0]       r_grant;
    logic [CNT_W-1:0] r_cnt;

    logic       w_found;
    logic [2:0] w_sel;
    logic [3:0] w_scan;
    logic [7:0] w_ready8;

    // Round-robin scan starting at r_ptr; debug and reset suppress all grants.
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_scan   = '0;
        w_ready8 = '0;
        if (!reset && !dbg_we) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                w_scan = 4'(r_ptr) + 4'(k);
                if (w_scan >= N4) begin
                    w_scan = w_scan - N4;
                end
                if (!w_found && w_valid_arr[w_scan[2:0]]) begin
                    w_found = 1'b1;
                    w_sel   = w_scan[2:0];
                end
            end
            if (w_found) begin
                w_ready8[w_sel] = 1'b1;
            end
        end
    end

    assign req_ready = w_ready8[NUM_REQ-1:0];

    // Register the selected write, advance the pointer, count contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_wreg  <= '0;
            r_wdata <= '0;
            r_grant <= '0;
            r_cnt   <= '0;
        end else begin
            if (dbg_we) begin
                r_we    <= (dbg_reg != 5'd0);
                r_wreg  <= dbg_reg;
                r_wdata <= dbg_data;
            end else if (w_found) begin
                r_we    <= (w_reg_arr[w_sel] != 5'd0);
                r_wreg  <= w_reg_arr[w_sel];
                r_wdata <= w_data_arr[w_sel];
                r_grant <= w_sel;
                r_ptr   <= (w_sel == LAST_IDX) ? 3'd0 : w_sel + 3'd1;
            end else begin
                r_we    <= 1'b0;
            end
            if (((req_valid & ~req_ready) != '0) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign WriteEnable    = r_we;
    assign WriteRegister  = r_wreg;
    assign WriteData      = r_wdata;
    assign grant_id       = r_grant;
    assign contention_cnt = r_cnt;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a 16-bit-counter instance for the main
// function and a 4-bit-counter instance sharing the same stimulus for saturation.
module tb_wb_port_arbiter;

    logic         clk;
    logic         reset;
    logic [2:0]   req_valid;
    logic [14:0]  req_reg;
    logic [95:0]  req_data;
    logic         dbg_we;
    logic [4:0]   dbg_reg;
    logic [31:0]  dbg_data;

    logic [2:0]   ready_a;
    logic         we_a;
    logic [4:0]   wreg_a;
    logic [31:0]  wdata_a;
    logic [2:0]   gid_a;
    logic [15:0]  cnt_a;

    logic [2:0]   ready_b;
    logic         we_b;
    logic [4:0]   wreg_b;
    logic [31:0]  wdata_b;
    logic [2:0]   gid_b;
    logic [3:0]   cnt_b;

    int unsigned  n_checks;
    int unsigned  n_errors;

    wb_port_arbiter #(.NUM_REQ(3), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_reg(req_reg),
        .req_data(req_data), .req_ready(ready_a), .dbg_we(dbg_we),
        .dbg_reg(dbg_reg), .dbg_data(dbg_data), .WriteEnable(we_a),
        .WriteRegister(wreg_a), .WriteData(wdata_a), .grant_id(gid_a),
        .contention_cnt(cnt_a)
    );

    wb_port_arbiter #(.NUM_REQ(3), .CNT_W(4)) u_dut_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_reg(req_reg),
        .req_data(req_data), .req_ready(ready_b), .dbg_we(dbg_we),
        .dbg_reg(dbg_reg), .dbg_data(dbg_data), .WriteEnable(we_b),
        .WriteRegister(wreg_b), .WriteData(wdata_b), .grant_id(gid_b),
        .contention_cnt(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
        req_reg[i*5 +: 5]   = r;
        req_data[i*32 +: 32] = d;
    endtask

    // Advance one clock; registered outputs are stable 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b1;
        req_valid = 3'b111;
        req_reg   = '0;
        req_data  = '0;
        dbg_we    = 1'b0;
        dbg_reg   = '0;
        dbg_data  = '0;

        // Reset held two cycles with all requesters valid
        #1;
        check("rst_ready", 64'(ready_a), 64'h0);
        tick();
        tick();
        check("rst_ready2", 64'(ready_a), 64'h0);
        check("rst_we", 64'(we_a), 64'h0);
        check("rst_wreg", 64'(wreg_a), 64'h0);
        check("rst_wdata", 64'(wdata_a), 64'h0);
        check("rst_gid", 64'(gid_a), 64'h0);
        check("rst_cnt", 64'(cnt_a), 64'h0);

        // Single requester 0
        reset     = 1'b0;
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'hDEADBEEF);
        #1;
        check("single_ready", 64'(ready_a), 64'h1);
        tick();
        check("single_we", 64'(we_a), 64'h1);
        check("single_wreg", 64'(wreg_a), 64'd5);
        check("single_wdata", 64'(wdata_a), 64'hDEADBEEF);
        check("single_gid", 64'(gid_a), 64'h0);
        check("single_cnt", 64'(cnt_a), 64'h0);

        // Round robin from a fresh pointer
        reset = 1'b1;
        req_valid = 3'b000;
        tick();
        reset = 1'b0;
        set_req(0, 5'd1, 32'h11);
        set_req(1, 5'd2, 32'h22);
        set_req(2, 5'd3, 32'h33);
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            #1;
            check("rr_ready", 64'(ready_a), 64'(3'b001 << (k % 3)));
            tick();
            check("rr_gid", 64'(gid_a), 64'(k % 3));
            check("rr_wreg", 64'(wreg_a), 64'((k % 3) + 1));
            check("rr_we", 64'(we_a), 64'h1);
        end
        check("rr_cnt", 64'(cnt_a), 64'd6);

        // Write to $0 by requester 1 (pointer is 0)
        req_valid = 3'b010;
        set_req(1, 5'd0, 32'h1234);
        #1;
        check("r0_ready", 64'(ready_a), 64'h2);
        tick();
        check("r0_we", 64'(we_a), 64'h0);
        check("r0_wreg", 64'(wreg_a), 64'h0);
        check("r0_wdata", 64'(wdata_a), 64'h1234);
        check("r0_gid", 64'(gid_a), 64'h1);
        check("r0_cnt", 64'(cnt_a), 64'd6);

        // Debug port overrides all requesters
        req_valid = 3'b111;
        dbg_we    = 1'b1;
        dbg_reg   = 5'd31;
        dbg_data  = 32'hA5A5A5A5;
        #1;
        check("dbg_ready", 64'(ready_a), 64'h0);
        tick();
        check("dbg_we", 64'(we_a), 64'h1);
        check("dbg_wreg", 64'(wreg_a), 64'd31);
        check("dbg_wdata", 64'(wdata_a), 64'hA5A5A5A5);
        check("dbg_gid", 64'(gid_a), 64'h1);
        check("dbg_cnt", 64'(cnt_a), 64'd7);

        // Pointer stayed at 2 through the debug cycle
        dbg_we = 1'b0;
        #1;
        check("ptr_ready", 64'(ready_a), 64'h4);
        tick();
        check("ptr_gid", 64'(gid_a), 64'h2);
        check("ptr_wreg", 64'(wreg_a), 64'd3);
        check("ptr_cnt", 64'(cnt_a), 64'd8);

        // Idle cycle: write enable drops, data holds
        req_valid = 3'b000;
        #1;
        check("idle_ready", 64'(ready_a), 64'h0);
        tick();
        check("idle_we", 64'(we_a), 64'h0);
        check("idle_wreg", 64'(wreg_a), 64'd3);
        check("idle_wdata", 64'(wdata_a), 64'h33);
        check("idle_cnt", 64'(cnt_a), 64'd8);

        // Saturation of the 4-bit counter
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("sat_cnt0", 64'(cnt_b), 64'h0);
        set_req(1, 5'd2, 32'h22);
        req_valid = 3'b111;
        for (int k = 0; k < 20; k++) tick();
        check("sat_cnt_small", 64'(cnt_b), 64'd15);
        check("sat_cnt_wide", 64'(cnt_a), 64'd20);

        // Transfer (pointer 2 -> requester 0 wins), then reset with a live request
        req_valid = 3'b001;
        #1;
        check("pre_rst_ready", 64'(ready_a), 64'h1);
        tick();
        check("pre_rst_we", 64'(we_a), 64'h1);
        check("pre_rst_cnt_small", 64'(cnt_b), 64'd15);
        reset     = 1'b1;
        req_valid = 3'b111;
        dbg_we    = 1'b1;
        dbg_reg   = 5'd7;
        dbg_data  = 32'h77;
        #1;
        check("mid_rst_ready", 64'(ready_a), 64'h0);
        tick();
        check("post_rst_we", 64'(we_a), 64'h0);
        check("post_rst_wreg", 64'(wreg_a), 64'h0);
        check("post_rst_cnt", 64'(cnt_a), 64'h0);
        check("post_rst_cnt_small", 64'(cnt_b), 64'h0);
        check("post_rst_gid", 64'(gid_a), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
